// File: rtl/button_input_port_pkg.sv
// Shared constants for the button input port: bit positions, register
// addresses and the default debounce length.
package button_input_port_pkg;

  localparam int NUM_BTN = 4;

  localparam int BTN_RIGHT = 0;
  localparam int BTN_LEFT  = 1;
  localparam int BTN_DOWN  = 2;
  localparam int BTN_UP    = 3;

  localparam logic ADDR_LEVEL = 1'b0;
  localparam logic ADDR_EVENT = 1'b1;

  localparam int DEBOUNCE_CYCLES_DEF = 4;

endpackage

// File: rtl/button_input_port_btn_debounce.sv
// One button channel: two-flop synchronizer followed by a stable-count
// debouncer whose output level only moves after DEBOUNCE_CYCLES agreeing samples.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic i_raw,
  output logic o_db
);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_db;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_hit;

  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_hit     = (w_cnt_inc == CNT_W'(DEBOUNCE_CYCLES));
  assign o_db      = r_db;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_db    <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      // Any sample agreeing with the current level restarts the count.
      if (r_sync2 == r_db) begin
        r_cnt <= '0;
      end else if (w_hit) begin
        r_db  <= r_sync2;
        r_cnt <= '0;
      end else begin
        r_cnt <= w_cnt_inc;
      end
    end
  end

endmodule

// File: rtl/button_input_port.sv
// Memory-mapped button peripheral: debounced levels, sticky press events with
// overflow flags, a registered read port and a level interrupt.
module button_input_port
  import button_input_port_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        up,
  input  logic        down,
  input  logic        left,
  input  logic        right,
  input  logic        rd_en,
  input  logic        rd_addr,
  output logic [15:0] rd_data,
  output logic        rd_valid,
  output logic        irq
);

  logic [NUM_BTN-1:0] w_raw;
  logic [NUM_BTN-1:0] w_db;
  logic [NUM_BTN-1:0] w_press;
  logic [NUM_BTN-1:0] w_clr;
  logic [NUM_BTN-1:0] r_db_d;
  logic [NUM_BTN-1:0] r_event;
  logic [NUM_BTN-1:0] r_ovf;
  logic [15:0]        r_rd_data;
  logic               r_rd_valid;
  logic               w_rd_event;

  assign w_raw[BTN_RIGHT] = right;
  assign w_raw[BTN_LEFT]  = left;
  assign w_raw[BTN_DOWN]  = down;
  assign w_raw[BTN_UP]    = up;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BTN; gi++) begin : g_btn
      btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
      ) u_debounce (
        .clk  (clk),
        .reset(reset),
        .i_raw(w_raw[gi]),
        .o_db (w_db[gi])
      );
    end
  endgenerate

  assign w_press    = w_db & ~r_db_d;
  assign w_rd_event = rd_en && (rd_addr == ADDR_EVENT);
  // An EVENT read clears the bits it returns; a same-cycle press is OR-ed in after.
  assign w_clr      = w_rd_event ? {NUM_BTN{1'b1}} : {NUM_BTN{1'b0}};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_db_d     <= '0;
      r_event    <= '0;
      r_ovf      <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_db_d     <= w_db;
      r_event    <= (r_event & ~w_clr) | w_press;
      r_ovf      <= (r_ovf & ~w_clr) | (w_press & r_event & ~w_clr);
      r_rd_valid <= rd_en;
      if (rd_en) begin
        if (rd_addr == ADDR_EVENT) begin
          r_rd_data <= {8'b0, r_ovf, r_event};
        end else begin
          r_rd_data <= {12'b0, w_db};
        end
      end
    end
  end

  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;
  assign irq      = |r_event;

endmodule

// File: tb/tb_button_input_port.sv
// Directed bench for button_input_port: a vector table of press/read steps
// plus hand-timed sequences for read collisions, back-to-back reads and reset.
module tb_button_input_port;
  import button_input_port_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0;
  logic        rd_en = 1'b0;
  logic        rd_addr = 1'b0;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        irq;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [3:0]  btns;      // {up, down, left, right}
    int          hold;      // cycles held before the read
    logic        addr;
    logic [15:0] exp_data;
    logic        exp_irq;   // irq expected just before the read
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  button_input_port #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (8)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .up      (up),
    .down    (down),
    .left    (left),
    .right   (right),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .rd_valid(rd_valid),
    .irq     (irq)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic set_btn(input logic [3:0] b);
    {up, down, left, right} = b;
  endtask

  // One read transaction: strobe, check data/valid, then confirm valid drops.
  task automatic do_read(input string name, input logic a, input logic [15:0] exp);
    rd_en   = 1'b1;
    rd_addr = a;
    step();
    rd_en = 1'b0;
    $display("read %s addr=%0d data=%h valid=%b exp=%h", name, a, rd_data, rd_valid, exp);
    chk16({name, "_data"}, rd_data, exp);
    chk1({name, "_valid"}, rd_valid, 1'b1);
    step();
    chk1({name, "_valid_drop"}, rd_valid, 1'b0);
    chk16({name, "_hold"}, rd_data, exp);
  endtask

  initial begin
    // Reset: outputs must stay zero even with a read strobe present.
    reset   = 1'b0;
    rd_en   = 1'b1;
    rd_addr = ADDR_EVENT;
    step();
    step();
    chk16("rst_data", rd_data, 16'h0000);
    chk1("rst_valid", rd_valid, 1'b0);
    chk1("rst_irq", irq, 1'b0);
    rd_en = 1'b0;
    reset = 1'b1;

    vecs.push_back('{4'b0000,  3, ADDR_EVENT, 16'h0000, 1'b0});
    vecs.push_back('{4'b0001, 25, ADDR_LEVEL, 16'h0001, 1'b1});
    vecs.push_back('{4'b0001,  1, ADDR_EVENT, 16'h0001, 1'b1});
    vecs.push_back('{4'b0001,  1, ADDR_EVENT, 16'h0000, 1'b0});
    vecs.push_back('{4'b0000, 10, ADDR_LEVEL, 16'h0000, 1'b0});
    vecs.push_back('{4'b0000,  1, ADDR_EVENT, 16'h0000, 1'b0});
    // up glitch: high for 3 sampled cycles only
    vecs.push_back('{4'b1000,  1, ADDR_LEVEL, 16'h0000, 1'b0});
    vecs.push_back('{4'b0000, 10, ADDR_EVENT, 16'h0000, 1'b0});
    vecs.push_back('{4'b1000, 10, ADDR_LEVEL, 16'h0008, 1'b1});
    vecs.push_back('{4'b1000,  1, ADDR_EVENT, 16'h0008, 1'b1});
    vecs.push_back('{4'b0000, 10, ADDR_EVENT, 16'h0000, 1'b0});
    // down pressed twice without a read in between
    vecs.push_back('{4'b0100, 10, ADDR_LEVEL, 16'h0004, 1'b1});
    vecs.push_back('{4'b0000, 10, ADDR_LEVEL, 16'h0000, 1'b1});
    vecs.push_back('{4'b0100, 10, ADDR_LEVEL, 16'h0004, 1'b1});
    vecs.push_back('{4'b0000, 10, ADDR_EVENT, 16'h0044, 1'b1});
    vecs.push_back('{4'b0000,  1, ADDR_EVENT, 16'h0000, 1'b0});
    // all four together
    vecs.push_back('{4'b1111, 10, ADDR_EVENT, 16'h000F, 1'b1});
    vecs.push_back('{4'b1111,  1, ADDR_LEVEL, 16'h000F, 1'b0});
    vecs.push_back('{4'b0000, 10, ADDR_EVENT, 16'h0000, 1'b0});

    foreach (vecs[i]) begin
      set_btn(vecs[i].btns);
      repeat (vecs[i].hold) step();
      chk1($sformatf("v%0d_irq", i), irq, vecs[i].exp_irq);
      do_read($sformatf("v%0d", i), vecs[i].addr, vecs[i].exp_data);
    end

    // Collision: left's event lands in the read cycle while right is pending.
    set_btn(4'b0001);
    repeat (10) step();
    chk1("col_irq_pre", irq, 1'b1);
    set_btn(4'b0011);
    repeat (6) step();
    do_read("col_first", ADDR_EVENT, 16'h0001);
    chk1("col_irq_mid", irq, 1'b1);
    do_read("col_second", ADDR_EVENT, 16'h0002);
    chk1("col_irq_post", irq, 1'b0);
    set_btn(4'b0000);
    repeat (10) step();
    do_read("col_idle", ADDR_EVENT, 16'h0000);

    // Back-to-back reads on consecutive cycles.
    set_btn(4'b0001);
    repeat (10) step();
    rd_en   = 1'b1;
    rd_addr = ADDR_LEVEL;
    step();
    $display("read b2b_level data=%h valid=%b", rd_data, rd_valid);
    chk16("b2b_level_data", rd_data, 16'h0001);
    chk1("b2b_level_valid", rd_valid, 1'b1);
    rd_addr = ADDR_EVENT;
    step();
    $display("read b2b_event data=%h valid=%b", rd_data, rd_valid);
    chk16("b2b_event_data", rd_data, 16'h0001);
    chk1("b2b_event_valid", rd_valid, 1'b1);
    chk1("b2b_irq", irq, 1'b0);
    rd_en = 1'b0;
    step();
    chk1("b2b_valid_drop", rd_valid, 1'b0);
    chk16("b2b_hold", rd_data, 16'h0001);
    set_btn(4'b0000);
    repeat (10) step();

    // Async reset while up is held with its event pending.
    set_btn(4'b1000);
    repeat (10) step();
    do_read("pre_rst_level", ADDR_LEVEL, 16'h0008);
    chk1("pre_rst_irq", irq, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    $display("async reset asserted data=%h valid=%b irq=%b", rd_data, rd_valid, irq);
    chk16("arst_data", rd_data, 16'h0000);
    chk1("arst_valid", rd_valid, 1'b0);
    chk1("arst_irq", irq, 1'b0);
    step();
    step();
    chk1("arst_irq_held", irq, 1'b0);
    reset = 1'b1;
    repeat (6) step();
    chk1("rel_irq_early", irq, 1'b0);
    step();
    chk1("rel_irq_set", irq, 1'b1);
    do_read("rel_event", ADDR_EVENT, 16'h0008);
    do_read("rel_event_once", ADDR_EVENT, 16'h0000);
    set_btn(4'b0000);
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
